// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache/memory read arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 8;

  localparam int IS_IDLE = 0;
  localparam int IS_REQ  = 1;
  localparam int IS_RSP  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_RSP  = 3'b100
  } state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_sel.sv
// Grant selector for the read arbiter: fixed DC priority, or
// round-robin on ties when MEM_ARB_RR_EN is defined.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic ic_valid_i,
  input  logic dc_valid_i,
  input  logic last_grant_i,
  output logic owner_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    owner_o = OWN_IC;
    if (ic_valid_i && dc_valid_i) begin
      owner_o = (last_grant_i == OWN_IC) ? OWN_DC : OWN_IC;
    end else if (dc_valid_i) begin
      owner_o = OWN_DC;
    end
  end
`else
  logic unused_lg;
  assign unused_lg = last_grant_i;

  always_comb begin
    owner_o = dc_valid_i ? OWN_DC : OWN_IC;
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Two-master (IC/DC) burst read arbiter onto one memory read port.
// MEM_ARB_RR_EN selects round-robin instead of fixed DC priority.
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              from_ic_rd_req_valid,
  input  logic [ADDR_W-1:0] from_ic_rd_req_addr,
  input  logic [LEN_W-1:0]  from_ic_rd_req_len,
  output logic              to_ic_rd_req_ready,
  output logic              to_ic_rd_rsp_valid,
  output logic [DATA_W-1:0] to_ic_rd_rsp_data,
  output logic              to_ic_rd_rsp_last,
  input  logic              from_ic_rd_rsp_ready,

  input  logic              from_dc_rd_req_valid,
  input  logic [ADDR_W-1:0] from_dc_rd_req_addr,
  input  logic [LEN_W-1:0]  from_dc_rd_req_len,
  output logic              to_dc_rd_req_ready,
  output logic              to_dc_rd_rsp_valid,
  output logic [DATA_W-1:0] to_dc_rd_rsp_data,
  output logic              to_dc_rd_rsp_last,
  input  logic              from_dc_rd_rsp_ready,

  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  output logic [LEN_W-1:0]  to_mem_rd_req_len,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready,

  output logic              rd_len_err
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             sel_owner;
  logic             last_grant;
  logic             beat_acc;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_IC;
`endif

  mem_arb_sel u_sel (
    .ic_valid_i   (from_ic_rd_req_valid),
    .dc_valid_i   (from_dc_rd_req_valid),
    .last_grant_i (last_grant),
    .owner_o      (sel_owner)
  );

  assign rd_len_err = err_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    beat_acc   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    to_ic_rd_req_ready  = 1'b0;
    to_dc_rd_req_ready  = 1'b0;
    to_ic_rd_rsp_valid  = 1'b0;
    to_ic_rd_rsp_data   = '0;
    to_ic_rd_rsp_last   = 1'b0;
    to_dc_rd_rsp_valid  = 1'b0;
    to_dc_rd_rsp_data   = '0;
    to_dc_rd_rsp_last   = 1'b0;
    to_mem_rd_req_valid = 1'b0;
    to_mem_rd_req_addr  = '0;
    to_mem_rd_req_len   = '0;
    to_mem_rd_rsp_ready = 1'b0;

    unique case (1'b1)
      state_q[IS_IDLE]: begin
        if (from_ic_rd_req_valid || from_dc_rd_req_valid) begin
          state_d = ST_REQ;
          owner_d = sel_owner;
`ifdef MEM_ARB_RR_EN
          last_grant_d = sel_owner;
`endif
        end
      end
      state_q[IS_REQ]: begin
        if (owner_q == OWN_DC) begin
          to_mem_rd_req_valid = from_dc_rd_req_valid;
          to_mem_rd_req_addr  = from_dc_rd_req_addr;
          to_mem_rd_req_len   = from_dc_rd_req_len;
          to_dc_rd_req_ready  = from_mem_rd_req_ready;
        end else begin
          to_mem_rd_req_valid = from_ic_rd_req_valid;
          to_mem_rd_req_addr  = from_ic_rd_req_addr;
          to_mem_rd_req_len   = from_ic_rd_req_len;
          to_ic_rd_req_ready  = from_mem_rd_req_ready;
        end
        if (to_mem_rd_req_valid && from_mem_rd_req_ready) begin
          len_d      = to_mem_rd_req_len;
          beat_cnt_d = '0;
          state_d    = ST_RSP;
        end
      end
      state_q[IS_RSP]: begin
        if (owner_q == OWN_DC) begin
          to_dc_rd_rsp_valid  = from_mem_rd_rsp_valid;
          to_dc_rd_rsp_data   = from_mem_rd_rsp_data;
          to_dc_rd_rsp_last   = from_mem_rd_rsp_last;
          to_mem_rd_rsp_ready = from_dc_rd_rsp_ready;
        end else begin
          to_ic_rd_rsp_valid  = from_mem_rd_rsp_valid;
          to_ic_rd_rsp_data   = from_mem_rd_rsp_data;
          to_ic_rd_rsp_last   = from_mem_rd_rsp_last;
          to_mem_rd_rsp_ready = from_ic_rd_rsp_ready;
        end
        beat_acc = from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          // last must coincide exactly with the beat numbered len
          if (from_mem_rd_rsp_last != (beat_cnt_q == len_q)) begin
            err_d = 1'b1;
          end
          if (from_mem_rd_rsp_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IC;
      beat_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWN_IC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed and random
// bursts checked against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ic_v, dc_v;
  logic [31:0] ic_addr, dc_addr;
  logic [7:0]  ic_len, dc_len;
  logic        ic_rrdy, dc_rrdy;
  logic        to_ic_rd_req_ready, to_dc_rd_req_ready;
  logic        to_ic_rd_rsp_valid, to_dc_rd_rsp_valid;
  logic [31:0] to_ic_rd_rsp_data, to_dc_rd_rsp_data;
  logic        to_ic_rd_rsp_last, to_dc_rd_rsp_last;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic [7:0]  to_mem_rd_req_len;
  logic        mem_req_rdy;
  logic        mem_rsp_v;
  logic [31:0] mem_rsp_d;
  logic        mem_rsp_l;
  logic        to_mem_rd_rsp_ready;
  logic        rd_len_err;

  int checks = 0;
  int errors = 0;
  bit err_exp;
  bit lg;

  cache_mem_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .from_ic_rd_req_valid  (ic_v),
    .from_ic_rd_req_addr   (ic_addr),
    .from_ic_rd_req_len    (ic_len),
    .to_ic_rd_req_ready    (to_ic_rd_req_ready),
    .to_ic_rd_rsp_valid    (to_ic_rd_rsp_valid),
    .to_ic_rd_rsp_data     (to_ic_rd_rsp_data),
    .to_ic_rd_rsp_last     (to_ic_rd_rsp_last),
    .from_ic_rd_rsp_ready  (ic_rrdy),
    .from_dc_rd_req_valid  (dc_v),
    .from_dc_rd_req_addr   (dc_addr),
    .from_dc_rd_req_len    (dc_len),
    .to_dc_rd_req_ready    (to_dc_rd_req_ready),
    .to_dc_rd_rsp_valid    (to_dc_rd_rsp_valid),
    .to_dc_rd_rsp_data     (to_dc_rd_rsp_data),
    .to_dc_rd_rsp_last     (to_dc_rd_rsp_last),
    .from_dc_rd_rsp_ready  (dc_rrdy),
    .to_mem_rd_req_valid   (to_mem_rd_req_valid),
    .to_mem_rd_req_addr    (to_mem_rd_req_addr),
    .to_mem_rd_req_len     (to_mem_rd_req_len),
    .from_mem_rd_req_ready (mem_req_rdy),
    .from_mem_rd_rsp_valid (mem_rsp_v),
    .from_mem_rd_rsp_data  (mem_rsp_d),
    .from_mem_rd_rsp_last  (mem_rsp_l),
    .to_mem_rd_rsp_ready   (to_mem_rd_rsp_ready),
    .rd_len_err            (rd_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit w);
    return w ? to_dc_rd_req_ready : to_ic_rd_req_ready;
  endfunction
  function automatic logic rv(input bit w);
    return w ? to_dc_rd_rsp_valid : to_ic_rd_rsp_valid;
  endfunction
  function automatic logic rl(input bit w);
    return w ? to_dc_rd_rsp_last : to_ic_rd_rsp_last;
  endfunction
  function automatic logic [31:0] rd(input bit w);
    return w ? to_dc_rd_rsp_data : to_ic_rd_rsp_data;
  endfunction

  // Model of the grant decision: DC=1, IC=0.
  function automatic bit pick(input bit icv, input bit dcv);
`ifdef MEM_ARB_RR_EN
    if (icv && dcv) return ~lg;
`else
    if (icv && dcv) return 1'b1;
`endif
    return dcv;
  endfunction

  task automatic set_rrdy(input bit w, input logic v);
    if (w) dc_rrdy = v;
    else ic_rrdy = v;
  endtask

  task automatic serve(input bit w, input int last_at, input int req_stall,
                       input int stall_beat, input int stall_n,
                       input logic [31:0] base, input int abort_at);
    logic [31:0] tx[$];
    logic [31:0] rx[$];
    logic [31:0] ea;
    logic [7:0]  el;
    ea = w ? dc_addr : ic_addr;
    el = w ? dc_len : ic_len;
    chk("idle_out", {to_mem_rd_req_valid, to_ic_rd_req_ready,
                     to_dc_rd_req_ready, to_mem_rd_rsp_ready}, 0);
    step();
    for (int i = 0; i < req_stall; i++) begin
      chk("req_hold", {to_mem_rd_req_valid, rdy(w), rdy(!w)}, 3'b100);
      chk("req_hold_addr", to_mem_rd_req_addr, ea);
      step();
    end
    mem_req_rdy = 1'b1;
    #1;
    chk("req_hs", {to_mem_rd_req_valid, rdy(w), rdy(!w)}, 3'b110);
    chk("req_addr", to_mem_rd_req_addr, ea);
    chk("req_len", to_mem_rd_req_len, el);
    step();
    mem_req_rdy = 1'b0;
    if (w) dc_v = 1'b0;
    else ic_v = 1'b0;
    ic_rrdy = 1'b1;
    dc_rrdy = 1'b1;
    for (int b = 0; b <= last_at; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_rsp_v = 1'b0;
        #1;
        chk("bubble", {rv(w), rv(!w)}, 2'b00);
        step();
      end
      mem_rsp_v = 1'b1;
      mem_rsp_d = base + b;
      mem_rsp_l = (b == last_at);
      if (b == abort_at) begin
        #1;
        chk("pre_rst_route", rv(w), 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out", {to_mem_rd_req_valid, to_ic_rd_req_ready,
                        to_dc_rd_req_ready, to_mem_rd_rsp_ready,
                        to_ic_rd_rsp_valid, to_dc_rd_rsp_valid,
                        to_ic_rd_rsp_last, to_dc_rd_rsp_last,
                        rd_len_err}, 0);
        step();
        rst = 1'b0;
        mem_rsp_v = 1'b0;
        mem_rsp_l = 1'b0;
        ic_rrdy = 1'b0;
        dc_rrdy = 1'b0;
        err_exp = 1'b0;
        lg = 1'b0;
        return;
      end
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          set_rrdy(w, 1'b0);
          #1;
          chk("rsp_stall", {to_mem_rd_rsp_ready, rv(w)}, 2'b01);
          step();
        end
      end
      set_rrdy(w, 1'b1);
      #1;
      chk("beat", {to_mem_rd_rsp_ready, rv(w), rv(!w), rl(!w)}, 4'b1100);
      chk("beat_last", rl(w), (b == last_at));
      tx.push_back(base + b);
      if (rv(w)) rx.push_back(rd(w));
      step();
    end
    mem_rsp_v = 1'b0;
    mem_rsp_l = 1'b0;
    ic_rrdy = 1'b0;
    dc_rrdy = 1'b0;
    chk("rx_count", rx.size(), tx.size());
    for (int i = 0; i < tx.size() && i < rx.size(); i++) begin
      chk("rx_data", rx[i], tx[i]);
    end
    if (last_at != int'(el)) err_exp = 1'b1;
    chk("len_err", rd_len_err, err_exp);
  endtask

  // Serve every pending request in model-predicted grant order.
  task automatic drain(input bit rnd);
    bit w;
    int la;
    while (ic_v || dc_v) begin
      w = pick(ic_v, dc_v);
      lg = w;
      la = int'(w ? dc_len : ic_len);
      if (rnd && $urandom_range(0, 9) == 0) la = $urandom_range(0, 9);
      serve(w, la, rnd ? $urandom_range(0, 3) : 0,
            rnd ? $urandom_range(0, 7) : -1, $urandom_range(1, 3),
            $urandom, -1);
    end
  endtask

  initial begin
    rst = 1'b1;
    ic_v = 0; dc_v = 0; ic_addr = 0; dc_addr = 0; ic_len = 0; dc_len = 0;
    ic_rrdy = 0; dc_rrdy = 0; mem_req_rdy = 0;
    mem_rsp_v = 0; mem_rsp_d = 0; mem_rsp_l = 0;
    err_exp = 0;
    lg = 0;
    #2;
    chk("in_reset", {to_mem_rd_req_valid, to_ic_rd_req_ready,
                     to_dc_rd_req_ready, to_mem_rd_rsp_ready,
                     to_ic_rd_rsp_valid, to_dc_rd_rsp_valid, rd_len_err}, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("after_reset", {to_mem_rd_req_valid, to_ic_rd_req_ready,
                        to_dc_rd_req_ready, to_mem_rd_rsp_ready,
                        to_ic_rd_rsp_valid, to_dc_rd_rsp_valid,
                        rd_len_err}, 0);

    ic_addr = 32'h40; ic_len = 8'd7; ic_v = 1'b1;
    lg = pick(1'b1, 1'b0);
    serve(1'b0, 7, 0, -1, 0, 32'h10, -1);

    ic_addr = 32'h200; ic_len = 8'd7; ic_v = 1'b1;
    dc_addr = 32'h100; dc_len = 8'd0; dc_v = 1'b1;
    chk("tie_first_dc", pick(1'b1, 1'b1), 1'b1);
    lg = 1'b1;
    serve(1'b1, 0, 0, -1, 0, 32'hA0, -1);
    dc_addr = 32'h300; dc_len = 8'd3; dc_v = 1'b1;
    drain(1'b0);

    dc_addr = 32'h400; dc_len = 8'd2; dc_v = 1'b1;
    lg = 1'b1;
    serve(1'b1, 2, 5, -1, 0, 32'hB0, -1);

    ic_addr = 32'h500; ic_len = 8'd7; ic_v = 1'b1;
    lg = 1'b0;
    serve(1'b0, 7, 0, 3, 3, 32'hC0, -1);

    ic_addr = 32'h600; ic_len = 8'd7; ic_v = 1'b1;
    lg = 1'b0;
    serve(1'b0, 3, 0, -1, 0, 32'hD0, -1);
    dc_addr = 32'h700; dc_len = 8'd1; dc_v = 1'b1;
    lg = 1'b1;
    serve(1'b1, 1, 0, -1, 0, 32'hE0, -1);

    dc_addr = 32'h800; dc_len = 8'd7; dc_v = 1'b1;
    lg = 1'b1;
    serve(1'b1, 7, 0, -1, 0, 32'hF0, 2);
    ic_addr = 32'h900; ic_len = 8'd0; ic_v = 1'b1;
    lg = 1'b0;
    serve(1'b0, 0, 0, -1, 0, 32'h1234, -1);

    for (int k = 0; k < 25; k++) begin
      ic_v = 1'b0;
      dc_v = 1'b0;
      while (!(ic_v || dc_v)) begin
        ic_v = 1'($urandom_range(0, 1));
        dc_v = 1'($urandom_range(0, 1));
      end
      ic_addr = $urandom; ic_len = 8'($urandom_range(0, 7));
      dc_addr = $urandom; dc_len = 8'($urandom_range(0, 7));
      drain(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
